cw0_sequencer: RTL and testbench
================================

# cw0_sequencer

Self-timed clockwise seven-segment animation engine, the counterpart to the counterclockwise fill pattern. It owns the step counter and prescaler that the pattern lookup lacks. It fills segments a→b→c→d→e→f, then ends with an off/full blink, in one-shot or looping mode. It sits between the top-level control inputs and the segment output mux.

## Interface
- DIV_WIDTH, default 8: width of the prescaler and of i_div.
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  single-cycle request to (re)start the animation from step 0.
- i_loop  in  1  1 = wrap after step 7; 0 = stop after step 7. Sampled at every step-7 tick.
- i_en  in  1  tick enable; 0 freezes the prescaler and step, i.e. pause.
- i_div  in  DIV_WIDTH  step period minus one, in clocks. Captured on an accepted i_start.
- o_segment  out  7  {g,f,e,d,c,b,a}, active-high, registered.
- o_count  out  3  current step, registered.
- o_busy  out  1  high while in RUN.
- o_done  out  1  one-cycle pulse on one-shot completion.

## Operation
- States: IDLE, RUN.
- Reset (synchronous, i_rst=1 at an edge), effective the next cycle:
  - state=IDLE; o_segment=7'b0000000; o_count=0; o_busy=0; o_done=0; prescaler=0; captured divisor=0.
  - Reset overrides i_start and everything else, including mid-animation.
- IDLE:
  - Outputs hold o_segment=0 and o_count=0.
  - i_start=1 → RUN; step=0; prescaler=0; divisor←i_div.
- RUN:
  - Tick = i_en & (prescaler == divisor).
  - On a tick: prescaler←0; step advances.
  - With i_en=1 and no tick: prescaler increments.
  - With i_en=0: nothing changes.
- Step advance:
  - step<7: step+1.
  - step==7 and i_loop=1: step←0, stay in RUN.
  - step==7 and i_loop=0: →IDLE; o_done=1 for exactly one cycle; o_segment←0; o_count←0.
- Patterns (o_segment when busy):
  - 0: 0000001 (a)
  - 1: 0000011 (a,b)
  - 2: 0000111 (a,b,c)
  - 3: 0001111 (a,b,c,d)
  - 4: 0011111 (a,b,c,d,e)
  - 5: 0111111 (a,b,c,d,e,f)
  - 6 and 7: see Configuration.
  - Segment g (bit 6) is never lit.
- i_start in RUN restarts: step=0; prescaler=0; divisor re-captured; no o_done.
- i_start coincident with the step-7 terminal tick: restart wins, no o_done pulse.
- i_div changes while in RUN are ignored until the next start.

## Timing
- i_start sampled at edge N → at N+1: o_busy=1, o_count=0, o_segment=0000001.
- Each step lasts divisor+1 enabled clocks. Divisor 0 = one step per clock.
- One-shot run with i_en held high:
  - o_done is high for the cycle beginning at edge N+1+8·(divisor+1).
  - o_busy falls at that same edge.
- o_segment and o_count update on the same edge; there are no combinational paths from inputs to outputs.
- Pause via i_en=0 extends the current step by exactly the number of disabled cycles.

## Configuration
- CW0_BLINK_EN defined:
  - step 6 = 0000000 (off)
  - step 7 = 0111111 (full)
  - This gives a blink finale.
- CW0_BLINK_EN undefined: steps 6 and 7 both = 0111111, i.e. hold full.
- Step count, timing and done behaviour are identical in both builds.

## Structure
- Shared package holds:
  - the segment bit-index constants (SEG_A=0 … SEG_G=6);
  - the SEG_OFF and SEG_FULL constants;
  - the state enum {IDLE, RUN}.
- Sub-module cw0_pattern: combinational 3-bit step → 7-bit pattern lookup, containing the CW0_BLINK_EN switch. The sequencer registers its output.

## Test plan
- Reset mid-run:
  - Stimulus: i_div=2, i_loop=1, start; assert i_rst at step 4 for one cycle.
  - Response: next cycle o_segment=0, o_count=0, o_busy=0, o_done=0; no further activity without a new start.
- One-shot sequence:
  - Stimulus: i_div=3, i_loop=0, i_en=1, start at edge 0.
  - Response: o_segment steps 0000001, 0000011, 0000111, 0001111, 0011111, 0111111, then steps 6–7 per build, each lasting 4 cycles. o_done pulses once at edge 33; o_busy then 0.
- Loop:
  - Stimulus: i_div=0, i_loop=1.
  - Response: o_count cycles 0..7..0 every 8 clocks; o_done never asserts.
  - Then drop i_loop: completes at the next step-7 tick with a single o_done.
- Pause:
  - Stimulus: i_div=3, i_en=0 for 5 cycles during step 2.
  - Response: step 2 lasts 9 cycles; all other steps last 4.
- Restart collision:
  - Stimulus: i_start asserted on the step-7 terminal tick with i_loop=0.
  - Response: no o_done; next cycle o_count=0, o_segment=0000001, o_busy=1. New i_div captured.
- Build check:
  - Response: step 6 is 0000000 with CW0_BLINK_EN and 0111111 without; step 7 is 0111111 in both.

Source files
------------

// File: rtl/cw0_sequencer_pkg.sv
// Shared constants and state type for the clockwise fill sequencer.
package cw0_sequencer_pkg;

  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  localparam logic [6:0] SEG_OFF  = '0;
  localparam logic [6:0] SEG_FULL = 7'b0111111;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

endpackage

// File: rtl/cw0_sequencer_if.sv
// Control/status bundle between top-level controls and cw0_sequencer.
interface cw0_sequencer_if #(
  parameter int unsigned DIV_WIDTH = 8
);
  logic                 i_start;
  logic                 i_loop;
  logic                 i_en;
  logic [DIV_WIDTH-1:0] i_div;
  logic [6:0]           o_segment;
  logic [2:0]           o_count;
  logic                 o_busy;
  logic                 o_done;

  modport master (
    output i_start, i_loop, i_en, i_div,
    input  o_segment, o_count, o_busy, o_done
  );

  modport slave (
    input  i_start, i_loop, i_en, i_div,
    output o_segment, o_count, o_busy, o_done
  );
endinterface

// File: rtl/cw0_pattern.sv
// Step -> segment lookup for the clockwise fill; CW0_BLINK_EN turns step 6 off
// so that steps 6/7 form an off/full blink finale.
module cw0_pattern
  import cw0_sequencer_pkg::*;
(
  input  logic [2:0] step_i,
  output logic [6:0] pattern_o
);

  always_comb begin
    pattern_o = SEG_OFF;
    unique case (step_i)
      3'd0: pattern_o[SEG_A]       = 1'b1;
      3'd1: pattern_o[SEG_B:SEG_A] = '1;
      3'd2: pattern_o[SEG_C:SEG_A] = '1;
      3'd3: pattern_o[SEG_D:SEG_A] = '1;
      3'd4: pattern_o[SEG_E:SEG_A] = '1;
      3'd5: pattern_o             = SEG_FULL;
`ifdef CW0_BLINK_EN
      3'd6: pattern_o             = SEG_OFF;
`else
      3'd6: pattern_o             = SEG_FULL;
`endif
      3'd7: pattern_o             = SEG_FULL;
      default: pattern_o          = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/cw0_sequencer.sv
// Self-timed clockwise seven-segment animation engine (prescaler + step FSM).
// Optional build macro: CW0_BLINK_EN (handled in cw0_pattern).
module cw0_sequencer
  import cw0_sequencer_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  cw0_sequencer_if.slave  bus
);

  state_e               state_q, state_d;
  logic [2:0]           step_q, step_d;
  logic [DIV_WIDTH-1:0] presc_q, presc_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 fin_q, fin_d;
  logic                 tick;
  logic [6:0]           pattern;

  logic [6:0]           seg_q;
  logic [2:0]           count_q;
  logic                 busy_q;
  logic                 done_q;

  cw0_pattern u_pattern (
    .step_i    (step_q),
    .pattern_o (pattern)
  );

  assign tick = bus.i_en && (presc_q == div_q);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    presc_d = presc_q;
    div_d   = div_q;
    fin_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          state_d = RUN;
          step_d  = '0;
          presc_d = '0;
          div_d   = bus.i_div;
        end
      end
      RUN: begin
        // A start always wins, including over the step-7 terminal tick.
        if (bus.i_start) begin
          step_d  = '0;
          presc_d = '0;
          div_d   = bus.i_div;
        end else if (tick) begin
          presc_d = '0;
          if (step_q != 3'd7) begin
            step_d = step_q + 3'd1;
          end else if (bus.i_loop) begin
            step_d = '0;
          end else begin
            state_d = IDLE;
            step_d  = '0;
            fin_d   = 1'b1;
          end
        end else if (bus.i_en) begin
          presc_d = presc_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      presc_q <= '0;
      div_q   <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      presc_q <= presc_d;
      div_q   <= div_d;
      fin_q   <= fin_d;
    end
  end

  // Output stage registers the sequencer state one edge later, so outputs
  // follow an accepted start at N+1 and done/busy fall together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      seg_q   <= SEG_OFF;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      seg_q   <= (state_q == RUN) ? pattern : SEG_OFF;
      count_q <= (state_q == RUN) ? step_q : 3'd0;
      busy_q  <= (state_q == RUN);
      done_q  <= fin_q;
    end
  end

  assign bus.o_segment = seg_q;
  assign bus.o_count   = count_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_done    = done_q;

endmodule

// File: tb/tb_cw0_sequencer.sv
// Directed bench for cw0_sequencer; expectations are hand-derived edge counts.
module tb_cw0_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;

  cw0_sequencer_if #(.DIV_WIDTH(8)) bus ();

  cw0_sequencer #(.DIV_WIDTH(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] exp_pat(input int s);
    case (s)
      0: return 7'b0000001;
      1: return 7'b0000011;
      2: return 7'b0000111;
      3: return 7'b0001111;
      4: return 7'b0011111;
      5: return 7'b0111111;
`ifdef CW0_BLINK_EN
      6: return 7'b0000000;
`else
      6: return 7'b0111111;
`endif
      default: return 7'b0111111;
    endcase
  endfunction

  task automatic cmp(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk(input string tag, input logic [6:0] seg, input int cnt,
                     input logic busy, input logic done);
    cmp({tag, ".seg"},  8'(bus.o_segment), 8'(seg));
    cmp({tag, ".cnt"},  8'(bus.o_count),   8'(cnt));
    cmp({tag, ".busy"}, 8'(bus.o_busy),    8'(busy));
    cmp({tag, ".done"}, 8'(bus.o_done),    8'(done));
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  // Pulses i_start across one edge (edge 0 of a sequence).
  task automatic start_run(input logic [7:0] div, input logic loop);
    bus.i_div   = div;
    bus.i_loop  = loop;
    bus.i_start = 1'b1;
    step_clk();
    bus.i_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_start = 1'b0;
    bus.i_loop  = 1'b0;
    bus.i_en    = 1'b1;
    bus.i_div   = 8'd0;

    // Reset state
    step_clk();
    step_clk();
    chk("reset", 7'b0, 0, 1'b0, 1'b0);
    rst = 1'b0;
    step_clk();
    chk("idle", 7'b0, 0, 1'b0, 1'b0);

    // One-shot, divisor 3; i_div change after start must be ignored
    start_run(8'd3, 1'b0);
    bus.i_div = 8'd0;
    chk("os_e0", 7'b0, 0, 1'b0, 1'b0);
    for (int e = 1; e <= 32; e++) begin
      step_clk();
      chk("oneshot", exp_pat((e - 1) / 4), (e - 1) / 4, 1'b1, 1'b0);
    end
    step_clk();
    chk("os_done", 7'b0, 0, 1'b0, 1'b1);
    step_clk();
    chk("os_after", 7'b0, 0, 1'b0, 1'b0);

    // Pause 5 cycles inside step 2: step 2 visible edges 9..17
    start_run(8'd3, 1'b0);
    for (int e = 1; e <= 8; e++) step_clk();
    chk("pz_e8", exp_pat(1), 1, 1'b1, 1'b0);
    step_clk();
    chk("pz_e9", exp_pat(2), 2, 1'b1, 1'b0);
    bus.i_en = 1'b0;
    for (int e = 10; e <= 14; e++) step_clk();
    chk("pz_frozen", exp_pat(2), 2, 1'b1, 1'b0);
    bus.i_en = 1'b1;
    for (int e = 15; e <= 17; e++) step_clk();
    chk("pz_e17", exp_pat(2), 2, 1'b1, 1'b0);
    step_clk();
    chk("pz_e18", exp_pat(3), 3, 1'b1, 1'b0);
    for (int e = 19; e <= 37; e++) step_clk();
    chk("pz_e37", exp_pat(7), 7, 1'b1, 1'b0);
    step_clk();
    chk("pz_done", 7'b0, 0, 1'b0, 1'b1);

    // Loop with divisor 0, then drop i_loop
    start_run(8'd0, 1'b1);
    for (int e = 1; e <= 20; e++) begin
      step_clk();
      chk("loop", exp_pat((e - 1) % 8), (e - 1) % 8, 1'b1, 1'b0);
    end
    bus.i_loop = 1'b0;
    for (int e = 21; e <= 24; e++) begin
      step_clk();
      chk("loop_tail", exp_pat((e - 1) % 8), (e - 1) % 8, 1'b1, 1'b0);
    end
    step_clk();
    chk("loop_done", 7'b0, 0, 1'b0, 1'b1);
    step_clk();
    chk("loop_after", 7'b0, 0, 1'b0, 1'b0);

    // Restart on the terminal tick: no done, new divisor 2 captured
    start_run(8'd0, 1'b0);
    for (int e = 1; e <= 7; e++) step_clk();
    bus.i_div   = 8'd2;
    bus.i_start = 1'b1;
    step_clk();
    bus.i_start = 1'b0;
    bus.i_div   = 8'd7;
    chk("rc_e8", exp_pat(7), 7, 1'b1, 1'b0);
    for (int e = 9; e <= 11; e++) begin
      step_clk();
      chk("rc_step0", 7'b0000001, 0, 1'b1, 1'b0);
    end
    step_clk();
    chk("rc_step1", 7'b0000011, 1, 1'b1, 1'b0);

    // Reset mid-run at step 4 (divisor 2, looping)
    start_run(8'd2, 1'b1);
    for (int e = 1; e <= 13; e++) step_clk();
    chk("rm_step4", exp_pat(4), 4, 1'b1, 1'b0);
    rst = 1'b1;
    step_clk();
    rst = 1'b0;
    chk("rm_reset", 7'b0, 0, 1'b0, 1'b0);
    for (int e = 0; e < 12; e++) step_clk();
    chk("rm_quiet", 7'b0, 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
